// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcodes, ALU operation codes and datapath mux select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation decode from funct3/funct7 for R-type and I-type instructions.
module mc_alu_decode
  import multicycle_controller_pkg::*;
(
  input  logic       op_5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // Only R-type (op[5]=1) can encode sub; addi ignores funct7.
      3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory,
// ALU and branch/jump steps and drives datapath selects and write strobes.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);

  state_t     state_reg;
  state_t     state_next;
  logic       ready;
  logic [2:0] dec_alu_control;
  logic       pc_write_c;
  logic       ir_write_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic       illegal_c;

  assign ready = WAIT_EN ? mem_ready : 1'b1;

  mc_alu_decode u_alu_decode (
    .op_5        (op[5]),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu_control)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALU_OUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_control = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
        ir_write_c = ready;
        pc_write_c = ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        illegal_c = !is_legal_op(op);
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_MEM_DATA;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRC_A_RS1;
        alu_control = dec_alu_control;
      end
      S_EXECI: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = dec_alu_control;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BEQ: begin
        alu_src_a   = SRC_A_RS1;
        alu_control = ALU_SUB;
        pc_write_c  = zero;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by rst_n so they drop at once, not at the next edge.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign illegal   = illegal_c   & rst_n;

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: imm_src = IMM_I;
      OP_SW:           imm_src = IMM_S;
      OP_BEQ:          imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      default:         imm_src = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full output bundle to hand-computed values.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [16:0] outs;

  int n_checks = 0;
  int n_fails  = 0;

  multicycle_controller #(.WAIT_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control};

  // Packs hand-chosen field values in the same order as outs.
  function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic irw,
                                     input logic mw, input logic rw, input logic ill,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] imm,
                                     input logic [2:0] alu);
    return {pcw, adr, irw, mw, rw, ill, rs, a, b, imm, alu};
  endfunction

  task automatic check_now(input string tag, input logic [16:0] expected);
    n_checks++;
    assert (outs === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, outs, expected);
    end
    $display("t=%0t %s outs=%b", $time, tag, outs);
  endtask

  // Inputs are set just after a falling edge; check 1 time unit later, then
  // step past the next rising edge to the following falling edge.
  task automatic cyc(input string tag, input logic [16:0] expected);
    #1;
    check_now(tag, expected);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #2;
    check_now("reset_fetch_no_strobes", ov(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // lw, no wait states
    op = 7'b0000011;
    cyc("lw_fetch",   ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("lw_decode",  ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("lw_memadr",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000));
    cyc("lw_memread", ov(0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000));
    cyc("lw_memwb",   ov(0,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00,3'b000));

    // sw with one fetch stall and three MEMWRITE stalls
    op = 7'b0100011; mem_ready = 1'b0;
    cyc("sw_fetch_stall", ov(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000));
    mem_ready = 1'b1;
    cyc("sw_fetch",   ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000));
    cyc("sw_decode",  ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000));
    cyc("sw_memadr",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000));
    mem_ready = 1'b0;
    cyc("sw_memwrite_w1", ov(0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000));
    cyc("sw_memwrite_w2", ov(0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000));
    cyc("sw_memwrite_w3", ov(0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000));
    mem_ready = 1'b1;
    cyc("sw_memwrite_done", ov(0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000));

    // beq taken
    op = 7'b1100011; zero = 1'b1;
    cyc("beq1_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000));
    cyc("beq1_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000));
    cyc("beq1_taken",  ov(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001));
    // beq not taken
    zero = 1'b0;
    cyc("beq2_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000));
    cyc("beq2_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000));
    cyc("beq2_not_taken", ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    cyc("rsub_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("rsub_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("rsub_execr",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001));
    cyc("rsub_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,3'b000));

    // R-type or
    funct3 = 3'b110; funct7_5 = 1'b0;
    cyc("ror_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("ror_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("ror_execr",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b011));
    funct3 = 3'b111;
    cyc("ror_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,3'b000));

    // R-type and
    cyc("rand_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("rand_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("rand_execr",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b010));
    cyc("rand_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,3'b000));

    // I-type with funct7_5=1 still adds
    op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    cyc("iadd_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("iadd_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("iadd_execi",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000));
    cyc("iadd_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,3'b000));

    // I-type slt
    funct3 = 3'b010; funct7_5 = 1'b0;
    cyc("islt_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("islt_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));
    cyc("islt_execi",  ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b101));
    cyc("islt_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,3'b000));

    // jal
    op = 7'b1101111;
    cyc("jal_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b11,3'b000));
    cyc("jal_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11,3'b000));
    cyc("jal_jal",    ov(1,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b11,3'b000));
    cyc("jal_aluwb",  ov(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b11,3'b000));

    // illegal opcode
    op = 7'b1111111;
    cyc("ill_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("ill_decode", ov(0,0,0,0,0,1, 2'b00,2'b01,2'b01,2'b00,3'b000));
    mem_ready = 1'b0;
    cyc("ill_back_to_fetch", ov(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));

    // reset in the middle of a stalled MEMWRITE
    op = 7'b0100011; mem_ready = 1'b1;
    cyc("rst_sw_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000));
    cyc("rst_sw_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000));
    cyc("rst_sw_memadr", ov(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000));
    mem_ready = 1'b0;
    #1;
    check_now("rst_sw_memwrite", ov(0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000));
    #1;
    rst_n = 1'b0;
    #1;
    check_now("rst_mid_memwrite_drop", ov(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_now("rst_held_no_strobes", ov(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000));
    @(negedge clk);
    rst_n = 1'b1; op = 7'b0000011;
    cyc("post_rst_fetch",  ov(1,0,1,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000));
    cyc("post_rst_decode", ov(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
